intr_control: RTL and testbench
===============================

Name: intr_control

Overview:
- Interrupt scheduler for the 8085-style core.
- Synchronises and latches TRAP, RST7.5, RST6.5, RST5.5 and INTR, and applies the SIM mask and interrupt-enable (IE) state.
- At each instruction boundary presented by the cycle controller, selects the highest-priority pending source.
- Holds a request with its source and vector address until the controller acknowledges it; also supplies the RIM status byte.

Parameters:
- SYNC_STAGES, 2, number of flops in each external-pin synchroniser (minimum 1).
- PRIO_LOCK, 1, when 1, a source is frozen in ireq until iack; when 0, a higher-priority arrival may replace the pending source before iack.

Ports:
- clk_ in 1: clock; all state changes on its rising edge.
- rst_ in 1: asynchronous reset, active-low.
- pin_trap, pin_r75, pin_r65, pin_r55, pin_intr in 1 each: raw external interrupt pins.
- ckpt in 1: one-clock instruction-boundary strobe from the cycle controller.
- halt in 1: core is in halt state; sampling occurs every clock while high.
- ei, di in 1: one-clock strobes issued during EI/DI execution.
- sim_wr in 1: one-clock strobe during SIM execution.
- acc in 8: accumulator value used by SIM.
- iack in 1: controller has taken the vector; one-clock strobe.
- ireq out 1: interrupt request pending to the controller.
- isrc out 3: source code: 0 none, 1 TRAP, 2 R7.5, 3 R6.5, 4 R5.5, 5 INTR.
- ivadd out 16: restart address.
- is_intr out 1: INTR selected; controller must run an INTA cycle instead of using ivadd.
- rim_dat out 8: RIM value.

Behaviour:
- Reset values: ireq=0, isrc=0, ivadd=0, is_intr=0, masks=3'b111, IE=0, r75 latch=0, trap latch=0, ei_pend=0. rim_dat follows from these registers.
- Synchronisers: every pin passes through SYNC_STAGES flops. Rise detect compares the synchronised value with its one-clock-delayed copy.
- TRAP:
  - Set on a synchronised rise; cleared on iack with isrc=1, or when the synchronised level falls.
  - Effective only while latch=1 and the level is high.
  - Non-maskable and ignores IE.
- R7.5:
  - Set on a synchronised rise regardless of mask.
  - Cleared on iack with isrc=2, or by SIM with acc[3]=1 and acc[4]=1.
  - If a rise and a SIM clear occur in the same clock, set wins.
- R6.5, R5.5, INTR: level-sensitive on the synchronised value; no latch.
- Eligibility: TRAP always; R7.5/R6.5/R5.5 need IE=1 and mask bit=0; INTR needs IE=1.
- Priority: TRAP > R7.5 > R6.5 > R5.5 > INTR.
- Sampling (ckpt=1, or halt=1, while ireq=0): if any source is eligible, then on the next edge:
  - ireq=1, isrc and ivadd registered, IE=0.
  - Vectors: TRAP 0x0024, R7.5 0x003C, R6.5 0x0034, R5.5 0x002C, INTR 0x0000 with is_intr=1.
- Pending (ireq=1):
  - ckpt is ignored.
  - With PRIO_LOCK=0, a newly eligible TRAP replaces a lower pending source.
  - iack clears ireq, isrc, ivadd, is_intr and the source latch on the next edge.
  - iack while ireq=0 is ignored.
- FSM has two states, IDLE and PEND. IDLE goes to PEND on an accepted sample; PEND returns to IDLE on iack.
- EI: sets ei_pend. IE becomes 1 at the edge of the next ckpt, so the boundary that ends the EI instruction does not itself see IE=1.
- DI: clears IE and ei_pend immediately. If ei and di occur in the same clock, di wins.
- SIM:
  - acc[3]=1 loads masks from acc[2:0] (bit2 R7.5, bit1 R6.5, bit0 R5.5); acc[3]=0 leaves masks unchanged.
  - acc[4] resets R7.5 as described above.
- rim_dat (combinational from registers): [7] SID or 0, [6] synchronised R7.5 latch, [5] R6.5 level, [4] R5.5 level, [3] IE, [2:0] masks.
- Reset asserted mid-operation aborts any pending request with no acknowledge required.

Optional Feature:
- Macro INTC_SERIAL_EN.
- Defined:
  - Adds port pin_sid (in, 1), synchronised into rim_dat[7].
  - Adds port pin_sod (out, 1; reset 0). SIM with acc[6]=1 loads pin_sod from acc[7]; acc[6]=0 leaves it unchanged.
- Undefined: neither port exists and rim_dat[7]=0.

Decomposition:
- Shared package (core85_pkg):
  - source codes 0..5;
  - the four vector constants;
  - SIM bit positions (MSE=3, R75=4, SOE=6, SOD=7);
  - RIM bit positions;
  - FSM state encodings.
- Sub-module intr_sync_edge: SYNC_STAGES synchroniser plus rise detector with outputs lvl and rise. Instantiated once per pin, and for SID when enabled.

Test Plan:
- Reset, then EI strobe, then ckpt, then R6.5 held high, then a second ckpt -> ireq=1, isrc=3, ivadd=0x0034 two clocks after that ckpt plus sync delay; IE=0; iack clears ireq.
- Masks=111 via SIM acc=0x0F; pulse R7.5 for one clock; SIM acc=0x08, then ckpt -> latched R7.5 is served with ivadd=0x003C; rim_dat[6]=1 before, 0 after iack.
- IE=0, TRAP raised and held, ckpt -> isrc=1, ivadd=0x0024. Repeat with TRAP dropped before ckpt -> no ireq.
- IE=1, R5.5 and INTR both high, ckpt -> isrc=4, is_intr=0. With R5.5 masked -> isrc=5, is_intr=1.
- SIM acc=0x18 issued in the same clock as an R7.5 rise -> latch remains 1.
- ei and di in the same clock, then two ckpts with R6.5 high -> no ireq.
- halt=1 with ckpt=0 and IE=1, R5.5 raised -> ireq within SYNC_STAGES+2 clocks.
- With INTC_SERIAL_EN defined: SIM acc=0xC0 -> pin_sod=1; SIM acc=0x80 -> pin_sod unchanged.

Source files
------------

// File: rtl/core85_pkg.sv
// core85_pkg: shared constants for the 8085-style core interrupt logic
// Contents: interrupt source codes, restart vectors, SIM/RIM bit positions,
//   scheduler FSM encodings and a source-to-vector lookup.
package core85_pkg;
    localparam logic [2:0] SRC_NONE = 3'd0;
    localparam logic [2:0] SRC_TRAP = 3'd1;
    localparam logic [2:0] SRC_R75  = 3'd2;
    localparam logic [2:0] SRC_R65  = 3'd3;
    localparam logic [2:0] SRC_R55  = 3'd4;
    localparam logic [2:0] SRC_INTR = 3'd5;

    localparam logic [15:0] VEC_TRAP = 16'h0024;
    localparam logic [15:0] VEC_R75  = 16'h003C;
    localparam logic [15:0] VEC_R65  = 16'h0034;
    localparam logic [15:0] VEC_R55  = 16'h002C;

    localparam int SIM_MSE = 3;
    localparam int SIM_R75 = 4;
    localparam int SIM_SOE = 6;
    localparam int SIM_SOD = 7;

    localparam int RIM_SID = 7;
    localparam int RIM_I75 = 6;
    localparam int RIM_I65 = 5;
    localparam int RIM_I55 = 4;
    localparam int RIM_IE  = 3;

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_PEND = 1'b1;

    // INTR (and none) return 0: INTR is vectored by the INTA cycle instead
    function automatic logic [15:0] src_vec(input logic [2:0] src);
        return (src == SRC_TRAP) ? VEC_TRAP :
               (src == SRC_R75)  ? VEC_R75  :
               (src == SRC_R65)  ? VEC_R65  :
               (src == SRC_R55)  ? VEC_R55  : 16'h0000;
    endfunction
endpackage

// File: rtl/intr_sync_edge.sv
// intr_sync_edge: multi-flop pin synchroniser with rising-edge detect
// Ports: clk_ clock; rst_ async active-low reset; pin raw input;
//   lvl synchronised level; rise one-clock pulse on a synchronised 0->1.
module intr_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_,
    input  logic rst_,
    input  logic pin,
    output logic lvl,
    output logic rise
);
    // sr[SYNC_STAGES-1] is the synchronised level; the extra top bit is its delayed copy
    logic [SYNC_STAGES:0] sr;

    always_ff @(posedge clk_ or negedge rst_) begin
        if (!rst_) sr <= '0;
        else       sr <= {sr[SYNC_STAGES-1:0], pin};
    end

    assign lvl  = sr[SYNC_STAGES-1];
    assign rise = lvl & ~sr[SYNC_STAGES];
endmodule

// File: rtl/intr_control.sv
// intr_control: 8085-style interrupt scheduler (sync, latch, mask, prioritise, vector)
// Ports: clk_ clock; rst_ async active-low reset; pin_trap/r75/r65/r55/intr raw pins;
//   ckpt instruction boundary; halt samples every clock; ei/di IE strobes;
//   sim_wr/acc SIM write; iack vector taken; ireq/isrc/ivadd/is_intr pending request;
//   rim_dat RIM status byte.
// Build option INTC_SERIAL_EN: adds pin_sid (into rim_dat[7]) and pin_sod (SIM serial out).
module intr_control
    import core85_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter bit PRIO_LOCK   = 1'b1
) (
    input  logic        clk_,
    input  logic        rst_,
    input  logic        pin_trap,
    input  logic        pin_r75,
    input  logic        pin_r65,
    input  logic        pin_r55,
    input  logic        pin_intr,
    input  logic        ckpt,
    input  logic        halt,
    input  logic        ei,
    input  logic        di,
    input  logic        sim_wr,
    input  logic [7:0]  acc,
    input  logic        iack,
    output logic        ireq,
    output logic [2:0]  isrc,
    output logic [15:0] ivadd,
    output logic        is_intr,
    output logic [7:0]  rim_dat
`ifdef INTC_SERIAL_EN
    ,
    input  logic        pin_sid,
    output logic        pin_sod
`endif
);
    logic [4:0] pins, lvl, rise;
    logic [2:0] mask, pick;
    logic       ie, ei_pend, r75_l, trap_l, state, trap_eff, take, ack, preempt, sid;
    logic       unused_bits;

    assign pins = {pin_intr, pin_r55, pin_r65, pin_r75, pin_trap};

    intr_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync [4:0] (
        .clk_ (clk_),
        .rst_ (rst_),
        .pin  (pins),
        .lvl  (lvl),
        .rise (rise)
    );

`ifdef INTC_SERIAL_EN
    logic sid_rise;
    intr_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sid (
        .clk_ (clk_),
        .rst_ (rst_),
        .pin  (pin_sid),
        .lvl  (sid),
        .rise (sid_rise)
    );
    assign unused_bits = ^{rise[4:2], sid_rise, acc[5]};

    always_ff @(posedge clk_ or negedge rst_) begin
        if (!rst_)                      pin_sod <= 1'b0;
        else if (sim_wr && acc[SIM_SOE]) pin_sod <= acc[SIM_SOD];
    end
`else
    assign sid         = 1'b0;
    assign unused_bits = ^{rise[4:2], acc[7:5]};
`endif

    // TRAP counts only while both the edge latch and the level are still high
    assign trap_eff = trap_l & lvl[0];
    assign pick = trap_eff                       ? SRC_TRAP :
                  (ie && !mask[2] && r75_l)      ? SRC_R75  :
                  (ie && !mask[1] && lvl[2])     ? SRC_R65  :
                  (ie && !mask[0] && lvl[3])     ? SRC_R55  :
                  (ie && lvl[4])                 ? SRC_INTR : SRC_NONE;
    assign take    = (state == ST_IDLE) && (ckpt || halt) && (pick != SRC_NONE);
    assign ack     = (state == ST_PEND) && iack;
    // only TRAP can outrank a pending source, so pick is TRAP whenever this fires
    assign preempt = !PRIO_LOCK && (state == ST_PEND) && !iack && trap_eff && (isrc != SRC_TRAP);

    always_ff @(posedge clk_ or negedge rst_) begin
        if (!rst_) begin
            state   <= ST_IDLE;
            isrc    <= SRC_NONE;
            ivadd   <= 16'h0000;
            is_intr <= 1'b0;
            mask    <= 3'b111;
            ie      <= 1'b0;
            ei_pend <= 1'b0;
            r75_l   <= 1'b0;
            trap_l  <= 1'b0;
        end else begin
            trap_l  <= rise[0] | (trap_l & lvl[0] & ~(ack & (isrc == SRC_TRAP)));
            // a new R7.5 edge beats a same-clock SIM reset
            r75_l   <= rise[1] | (r75_l & ~(ack & (isrc == SRC_R75)) & ~(sim_wr & acc[SIM_MSE] & acc[SIM_R75]));
            mask    <= (sim_wr && acc[SIM_MSE]) ? acc[2:0] : mask;
            ei_pend <= di ? 1'b0 : ei ? 1'b1 : ckpt ? 1'b0 : ei_pend;
            // EI takes effect after the boundary that ends the EI instruction
            ie      <= (di || take) ? 1'b0 : (ckpt && ei_pend) ? 1'b1 : ie;
            if (take || preempt) begin
                state   <= ST_PEND;
                isrc    <= pick;
                ivadd   <= src_vec(pick);
                is_intr <= (pick == SRC_INTR);
            end else if (ack) begin
                state   <= ST_IDLE;
                isrc    <= SRC_NONE;
                ivadd   <= 16'h0000;
                is_intr <= 1'b0;
            end
        end
    end

    assign ireq    = (state == ST_PEND);
    assign rim_dat = {sid, r75_l, lvl[2], lvl[3], ie, mask};
endmodule

// File: tb/tb_intr_control.sv
// tb_intr_control: directed scenarios plus randomized run against a behavioural model
module tb_intr_control;
    localparam int SS = 2;
    localparam bit PL = 1'b1;

    logic clk_ = 1'b0, rst_ = 1'b0;
    logic pin_trap = 0, pin_r75 = 0, pin_r65 = 0, pin_r55 = 0, pin_intr = 0, pin_sid = 0;
    logic ckpt = 0, halt = 0, ei = 0, di = 0, sim_wr = 0, iack = 0;
    logic [7:0] acc = 8'h00;
    logic ireq, is_intr;
    logic [2:0] isrc;
    logic [15:0] ivadd;
    logic [7:0] rim_dat;
`ifdef INTC_SERIAL_EN
    logic pin_sod;
`endif

    int checks = 0, passed = 0;

    always #5 clk_ = ~clk_;

    intr_control #(.SYNC_STAGES(SS), .PRIO_LOCK(PL)) dut (
        .clk_(clk_), .rst_(rst_),
        .pin_trap(pin_trap), .pin_r75(pin_r75), .pin_r65(pin_r65), .pin_r55(pin_r55), .pin_intr(pin_intr),
        .ckpt(ckpt), .halt(halt), .ei(ei), .di(di), .sim_wr(sim_wr), .acc(acc), .iack(iack),
        .ireq(ireq), .isrc(isrc), .ivadd(ivadd), .is_intr(is_intr), .rim_dat(rim_dat)
`ifdef INTC_SERIAL_EN
        , .pin_sid(pin_sid), .pin_sod(pin_sod)
`endif
    );

    // behavioural reference: pin history array stands in for the synchronisers
    logic [5:0] hist [0:7];
    logic m_pend, m_ie, m_eip, m_r75, m_trap, m_sod;
    logic [2:0] m_src, m_mask, m_best;
    logic [5:0] m_lv, m_rs;
    logic [5:1] m_el;
    logic m_ack, m_took;

    function automatic logic [15:0] ref_vec(input logic [2:0] s);
        case (s)
            3'd1: return 16'h0024;
            3'd2: return 16'h003C;
            3'd3: return 16'h0034;
            3'd4: return 16'h002C;
            default: return 16'h0000;
        endcase
    endfunction

    always @(posedge clk_ or negedge rst_) begin
        if (!rst_) begin
            m_pend = 0; m_src = 0; m_ie = 0; m_eip = 0; m_r75 = 0; m_trap = 0; m_sod = 0;
            m_mask = 3'b111;
            for (int i = 0; i < 8; i++) hist[i] = 6'd0;
        end else begin
            m_lv  = hist[SS-1];
            m_rs  = m_lv & ~hist[SS];
            m_ack = m_pend && iack;
            m_el[1] = m_trap && m_lv[0];
            m_el[2] = m_ie && !m_mask[2] && m_r75;
            m_el[3] = m_ie && !m_mask[1] && m_lv[2];
            m_el[4] = m_ie && !m_mask[0] && m_lv[3];
            m_el[5] = m_ie && m_lv[4];
            m_best = 0;
            for (int s = 5; s >= 1; s--) if (m_el[s]) m_best = 3'(s);
            m_took = !m_pend && (ckpt || halt) && m_best != 0;
            if (m_rs[0]) m_trap = 1;
            else if (!m_lv[0] || (m_ack && m_src == 1)) m_trap = 0;
            if (m_rs[1]) m_r75 = 1;
            else if ((m_ack && m_src == 2) || (sim_wr && acc[3] && acc[4])) m_r75 = 0;
            if (di) begin
                m_ie = 0; m_eip = 0;
            end else begin
                if (ckpt && m_eip) m_ie = 1;
                if (ei) m_eip = 1;
                else if (ckpt) m_eip = 0;
            end
            if (m_took) m_ie = 0;
            if (sim_wr && acc[3]) m_mask = acc[2:0];
            if (sim_wr && acc[6]) m_sod = acc[7];
            if (m_took) begin
                m_pend = 1; m_src = m_best;
            end else if (m_ack) begin
                m_pend = 0; m_src = 0;
            end else if (!PL && m_pend && m_best == 1 && m_src != 1) m_src = 1;
            for (int i = 7; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = {pin_sid, pin_intr, pin_r55, pin_r65, pin_r75, pin_trap};
        end
    end

    task automatic tick(); @(negedge clk_); endtask
    task automatic do_ckpt(); ckpt = 1; tick(); ckpt = 0; endtask
    task automatic do_ei(); ei = 1; tick(); ei = 0; endtask
    task automatic do_iack(); iack = 1; tick(); iack = 0; endtask
    task automatic do_sim(input logic [7:0] a); sim_wr = 1; acc = a; tick(); sim_wr = 0; acc = 0; endtask
    task automatic wait_ireq(input int n, output bit ok);
        for (int i = 0; i < n && !ireq; i++) tick();
        ok = ireq;
    endtask
    task automatic clear_inputs();
        {pin_trap, pin_r75, pin_r65, pin_r55, pin_intr, pin_sid} = '0;
        {ckpt, halt, ei, di, sim_wr, iack} = '0;
        acc = 8'h00;
    endtask

    task automatic test_reset();
        rst_ = 0; clear_inputs();
        repeat (2) tick();
        checks++; if ({ireq, isrc, is_intr} !== 5'b0) $display("FAIL reset_req got ireq=%0b isrc=%0d is_intr=%0b exp 0", ireq, isrc, is_intr); else passed++;
        checks++; if (ivadd !== 16'h0000) $display("FAIL reset_ivadd got=%h exp=0000", ivadd); else passed++;
        checks++; if (rim_dat !== 8'h07) $display("FAIL reset_rim got=%h exp=07", rim_dat); else passed++;
        rst_ = 1; tick();
    endtask

    task automatic test_r65();
        bit ok;
        do_sim(8'h08); do_ei(); do_ckpt();
        checks++; if (rim_dat[3] !== 1'b1) $display("FAIL r65_ie_on got=%0b exp=1", rim_dat[3]); else passed++;
        pin_r65 = 1; repeat (SS + 1) tick();
        do_ckpt(); wait_ireq(4, ok);
        checks++; if (!ok) $display("FAIL r65_ireq got=%0b exp=1", ireq); else passed++;
        checks++; if (isrc !== 3'd3 || ivadd !== 16'h0034) $display("FAIL r65_vec got isrc=%0d ivadd=%h exp 3/0034", isrc, ivadd); else passed++;
        checks++; if (rim_dat[3] !== 1'b0) $display("FAIL r65_ie_off got=%0b exp=0", rim_dat[3]); else passed++;
        do_iack();
        checks++; if (ireq !== 1'b0 || isrc !== 3'd0) $display("FAIL r65_iack got ireq=%0b isrc=%0d exp 0/0", ireq, isrc); else passed++;
        pin_r65 = 0; repeat (SS + 1) tick();
    endtask

    task automatic test_r75();
        bit ok;
        do_sim(8'h0F); do_ei(); do_ckpt();
        pin_r75 = 1; tick(); pin_r75 = 0; repeat (SS + 2) tick();
        do_ckpt(); tick();
        checks++; if (rim_dat[6] !== 1'b1) $display("FAIL r75_latched got=%0b exp=1", rim_dat[6]); else passed++;
        checks++; if (ireq !== 1'b0) $display("FAIL r75_masked got=%0b exp=0", ireq); else passed++;
        do_sim(8'h08); do_ckpt(); wait_ireq(4, ok);
        checks++; if (!ok || isrc !== 3'd2 || ivadd !== 16'h003C) $display("FAIL r75_vec got ireq=%0b isrc=%0d ivadd=%h exp 1/2/003C", ireq, isrc, ivadd); else passed++;
        do_iack();
        checks++; if (rim_dat[6] !== 1'b0 || ireq !== 1'b0) $display("FAIL r75_iack got rim6=%0b ireq=%0b exp 0/0", rim_dat[6], ireq); else passed++;
    endtask

    task automatic test_trap();
        bit ok;
        pin_trap = 1; repeat (SS + 1) tick();
        do_ckpt(); wait_ireq(4, ok);
        checks++; if (!ok || isrc !== 3'd1 || ivadd !== 16'h0024 || is_intr !== 1'b0) $display("FAIL trap_vec got ireq=%0b isrc=%0d ivadd=%h is_intr=%0b exp 1/1/0024/0", ireq, isrc, ivadd, is_intr); else passed++;
        do_iack(); do_ckpt(); tick();
        checks++; if (ireq !== 1'b0) $display("FAIL trap_no_retrigger got=%0b exp=0", ireq); else passed++;
        pin_trap = 0; repeat (SS + 2) tick();
        pin_trap = 1; repeat (SS + 2) tick();
        pin_trap = 0; repeat (SS + 2) tick();
        do_ckpt(); tick();
        checks++; if (ireq !== 1'b0) $display("FAIL trap_dropped got=%0b exp=0", ireq); else passed++;
    endtask

    task automatic test_r55_intr();
        bit ok;
        do_sim(8'h08); do_ei(); do_ckpt();
        pin_r55 = 1; pin_intr = 1; repeat (SS + 1) tick();
        do_ckpt(); wait_ireq(4, ok);
        checks++; if (!ok || isrc !== 3'd4 || is_intr !== 1'b0 || ivadd !== 16'h002C) $display("FAIL r55_over_intr got ireq=%0b isrc=%0d is_intr=%0b ivadd=%h exp 1/4/0/002C", ireq, isrc, is_intr, ivadd); else passed++;
        do_iack();
        do_sim(8'h09); do_ei(); do_ckpt(); do_ckpt(); wait_ireq(4, ok);
        checks++; if (!ok || isrc !== 3'd5 || is_intr !== 1'b1 || ivadd !== 16'h0000) $display("FAIL intr_sel got ireq=%0b isrc=%0d is_intr=%0b ivadd=%h exp 1/5/1/0000", ireq, isrc, is_intr, ivadd); else passed++;
        do_iack();
        pin_r55 = 0; pin_intr = 0; repeat (SS + 1) tick();
    endtask

    task automatic test_sim_same_clock();
        pin_r75 = 1; repeat (SS) tick();
        do_sim(8'h18);
        checks++; if (rim_dat[6] !== 1'b1) $display("FAIL r75_set_wins got=%0b exp=1", rim_dat[6]); else passed++;
        pin_r75 = 0; do_sim(8'h18);
        checks++; if (rim_dat[6] !== 1'b0) $display("FAIL r75_sim_clear got=%0b exp=0", rim_dat[6]); else passed++;
        repeat (SS + 1) tick();
    endtask

    task automatic test_ei_di();
        ei = 1; di = 1; tick(); ei = 0; di = 0;
        pin_r65 = 1; repeat (SS + 1) tick();
        do_ckpt(); do_ckpt(); tick();
        checks++; if (ireq !== 1'b0 || rim_dat[3] !== 1'b0) $display("FAIL di_wins got ireq=%0b ie=%0b exp 0/0", ireq, rim_dat[3]); else passed++;
        pin_r65 = 0; repeat (SS + 1) tick();
    endtask

    task automatic test_halt();
        bit ok;
        do_ei(); do_ckpt();
        pin_r55 = 1; halt = 1;
        wait_ireq(SS + 2, ok);
        checks++; if (!ok || isrc !== 3'd4) $display("FAIL halt_sample got ireq=%0b isrc=%0d exp 1/4", ireq, isrc); else passed++;
        halt = 0; do_iack();
        pin_r55 = 0; repeat (SS + 1) tick();
    endtask

    task automatic test_serial();
`ifdef INTC_SERIAL_EN
        do_sim(8'hC0);
        checks++; if (pin_sod !== 1'b1) $display("FAIL sod_set got=%0b exp=1", pin_sod); else passed++;
        do_sim(8'h80);
        checks++; if (pin_sod !== 1'b1) $display("FAIL sod_hold got=%0b exp=1", pin_sod); else passed++;
        do_sim(8'h40);
        checks++; if (pin_sod !== 1'b0) $display("FAIL sod_clear got=%0b exp=0", pin_sod); else passed++;
        pin_sid = 1; repeat (SS + 1) tick();
        checks++; if (rim_dat[7] !== 1'b1) $display("FAIL sid_rim got=%0b exp=1", rim_dat[7]); else passed++;
        pin_sid = 0; repeat (SS + 1) tick();
`else
        do_sim(8'hC0);
        checks++; if (rim_dat[7] !== 1'b0) $display("FAIL rim7_zero got=%0b exp=0", rim_dat[7]); else passed++;
`endif
    endtask

    task automatic test_reset_abort();
        bit ok;
        do_sim(8'h08); do_ei(); do_ckpt();
        pin_r65 = 1; repeat (SS + 1) tick();
        do_ckpt(); wait_ireq(4, ok);
        checks++; if (!ok) $display("FAIL abort_pre got=%0b exp=1", ireq); else passed++;
        #2 rst_ = 0;
        #1;
        checks++; if (ireq !== 1'b0 || isrc !== 3'd0 || ivadd !== 16'h0000) $display("FAIL abort_async got ireq=%0b isrc=%0d ivadd=%h exp 0/0/0000", ireq, isrc, ivadd); else passed++;
        pin_r65 = 0; tick(); rst_ = 1; tick();
    endtask

    task automatic test_random();
        logic [7:0] exp_rim;
        rst_ = 0; clear_inputs(); repeat (2) tick(); rst_ = 1; tick();
        for (int c = 0; c < 800; c++) begin
            if ($urandom_range(0, 7) == 0) pin_trap = ~pin_trap;
            if ($urandom_range(0, 7) == 0) pin_r75 = ~pin_r75;
            if ($urandom_range(0, 7) == 0) pin_r65 = ~pin_r65;
            if ($urandom_range(0, 7) == 0) pin_r55 = ~pin_r55;
            if ($urandom_range(0, 7) == 0) pin_intr = ~pin_intr;
            if ($urandom_range(0, 7) == 0) pin_sid = ~pin_sid;
            ckpt   = ($urandom_range(0, 3) == 0);
            halt   = ($urandom_range(0, 15) == 0);
            ei     = ($urandom_range(0, 7) == 0);
            di     = ($urandom_range(0, 19) == 0);
            sim_wr = ($urandom_range(0, 7) == 0);
            acc    = 8'($urandom);
            iack   = ireq ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 19) == 0);
            tick();
`ifdef INTC_SERIAL_EN
            exp_rim = {hist[SS-1][5], m_r75, hist[SS-1][2], hist[SS-1][3], m_ie, m_mask};
            checks++; if (pin_sod !== m_sod) $display("FAIL rand_sod cyc=%0d got=%0b exp=%0b", c, pin_sod, m_sod); else passed++;
`else
            exp_rim = {1'b0, m_r75, hist[SS-1][2], hist[SS-1][3], m_ie, m_mask};
`endif
            checks++;
            if ({ireq, isrc, ivadd, is_intr, rim_dat} !== {m_pend, m_src, ref_vec(m_src), m_src == 3'd5, exp_rim})
                $display("FAIL rand cyc=%0d got ireq=%0b isrc=%0d ivadd=%h is_intr=%0b rim=%h exp %0b/%0d/%h/%0b/%h",
                         c, ireq, isrc, ivadd, is_intr, rim_dat, m_pend, m_src, ref_vec(m_src), m_src == 3'd5, exp_rim);
            else passed++;
        end
        clear_inputs(); tick();
    endtask

    initial begin
        test_reset();
        test_r65();
        test_r75();
        test_trap();
        test_r55_intr();
        test_sim_same_clock();
        test_ei_di();
        test_halt();
        test_serial();
        test_reset_abort();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
